// File: rtl/control_dw_micro.sv
// Multi-cycle control FSM for the 8-bit micro write-back path.
// Fetch, decode, execute, data-memory wait and register write-back.
module control_dw_micro #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter int         MEM_TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [7:0]  o_pc,
  output logic        o_fetch_req,
  input  logic [15:0] i_instr,
  input  logic        i_instr_valid,
  output logic        o_mem_rd,
  output logic [7:0]  o_mem_addr,
  input  logic        i_mem_ack,
  output logic [2:0]  o_sel_dw,
  output logic [7:0]  o_num,
  output logic [7:0]  o_dir_instr,
  output logic [2:0]  o_rd_addr,
  output logic [2:0]  o_ry_addr,
  output logic        o_reg_wr,
  output logic        o_alu_en,
  output logic        o_err_illegal,
  output logic        o_err_timeout,
  output logic        o_halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_WAIT,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_LD   = 4'h3;
  localparam logic [3:0] OP_CALL = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_ALU  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state;
  logic [15:0] instr_q;
  logic [7:0]  cnt;
  logic [3:0]  op;
  logic [2:0]  sel_d;

  assign op         = instr_q[15:12];
  assign o_mem_addr = instr_q[7:0];

  // DW selector code for the latched opcode
  always_comb begin
    sel_d = 3'b000;
    case (op)
      OP_LDI:  sel_d = 3'b010;
      OP_MOV:  sel_d = 3'b100;
      OP_LD:   sel_d = 3'b001;
      OP_CALL: sel_d = 3'b011;
      default: sel_d = 3'b000;
    endcase
  end

  // Control state machine with registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= S_FETCH;
      instr_q       <= '0;
      cnt           <= '0;
      o_pc          <= RESET_PC;
      o_fetch_req   <= 1'b0;
      o_mem_rd      <= 1'b0;
      o_sel_dw      <= '0;
      o_num         <= '0;
      o_dir_instr   <= '0;
      o_rd_addr     <= '0;
      o_ry_addr     <= '0;
      o_reg_wr      <= 1'b0;
      o_alu_en      <= 1'b0;
      o_err_illegal <= 1'b0;
      o_err_timeout <= 1'b0;
      o_halted      <= 1'b0;
    end else begin
      o_reg_wr <= 1'b0;
      o_alu_en <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (o_fetch_req && i_instr_valid) begin
            instr_q     <= i_instr;
            o_pc        <= o_pc + 8'd1;
            o_fetch_req <= 1'b0;
            state       <= S_DECODE;
          end else begin
            o_fetch_req <= 1'b1;
          end
        end
        S_DECODE: begin
          o_num     <= instr_q[7:0];
          o_rd_addr <= instr_q[11:9];
          o_ry_addr <= instr_q[8:6];
          o_sel_dw  <= sel_d;
          state     <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            OP_LDI, OP_MOV: begin
              o_reg_wr <= 1'b1;
              state    <= S_WB;
            end
            OP_ALU: begin
              o_alu_en <= 1'b1;
              o_reg_wr <= 1'b1;
              state    <= S_WB;
            end
            OP_LD: begin
              o_mem_rd <= 1'b1;
              cnt      <= '0;
              state    <= S_MEM_WAIT;
            end
            OP_CALL: begin
              o_dir_instr <= o_pc;
              o_pc        <= o_num;
              o_reg_wr    <= 1'b1;
              state       <= S_WB;
            end
            OP_JMP: begin
              o_pc        <= o_num;
              o_fetch_req <= 1'b1;
              state       <= S_FETCH;
            end
            OP_NOP: begin
              o_fetch_req <= 1'b1;
              state       <= S_FETCH;
            end
            OP_HALT: begin
              o_halted <= 1'b1;
              state    <= S_HALT;
            end
            default: begin
              o_err_illegal <= 1'b1;
              o_fetch_req   <= 1'b1;
              state         <= S_FETCH;
            end
          endcase
        end
        S_MEM_WAIT: begin
          if (i_mem_ack) begin
            o_mem_rd <= 1'b0;
            o_reg_wr <= 1'b1;
            state    <= S_WB;
          end else if (cnt == TO_LAST) begin
            o_mem_rd      <= 1'b0;
            o_err_timeout <= 1'b1;
            o_fetch_req   <= 1'b1;
            state         <= S_FETCH;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WB: begin
          o_fetch_req <= 1'b1;
          state       <= S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule
